// File: rtl/dffram_nr1w_if.sv
// Bus bundle for dffram_nr1w: clear control, masked write port and NREAD read ports.
interface dffram_nr1w_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 24,
    parameter int unsigned NREAD = 2,
    parameter int unsigned LANE  = 4
);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NLANE = WIDTH / LANE;

    logic                   clear_req;
    logic                   busy;
    logic                   w_en;
    logic [AW-1:0]          w_addr;
    logic [WIDTH-1:0]       w_data;
    logic [NLANE-1:0]       w_mask;
    logic                   w_rej;
    logic                   wt_en;
    logic [NREAD-1:0]       rd_buf;
    logic [NREAD*AW-1:0]    r_addr;
    logic [NREAD*WIDTH-1:0] r_data;

    modport master (
        output clear_req, w_en, w_addr, w_data, w_mask, wt_en, rd_buf, r_addr,
        input  busy, w_rej, r_data
    );

    modport slave (
        input  clear_req, w_en, w_addr, w_data, w_mask, wt_en, rd_buf, r_addr,
        output busy, w_rej, r_data
    );
endinterface

// File: rtl/dffram_nr1w.sv
// Flip-flop RAM: one lane-masked write port, NREAD read ports with optional
// output register and write-through bypass, and a sequential clear engine
// that is the only way storage gets a known value.
module dffram_nr1w #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 24,
    parameter int unsigned NREAD = 2,
    parameter int unsigned LANE  = 4
) (
    input  logic           clk,
    input  logic           rst,
    dffram_nr1w_if.slave   bus
);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NLANE = WIDTH / LANE;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_busy;
    logic             w_waddr_ok;
    logic             w_rej;
    logic             w_acc;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_merged;

    assign w_busy     = (r_state == S_CLEAR);
    assign w_waddr_ok = ({1'b0, bus.w_addr} < DEPTH_X);
    assign w_rej      = bus.w_en & (w_busy | ~w_waddr_ok | (bus.w_mask == '0));
    assign w_acc      = bus.w_en & ~w_rej;
    assign bus.busy   = w_busy;
    assign bus.w_rej  = w_rej;

    // Clear engine state and word counter; reset starts a full clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clear engine next state: sweep words 0..DEPTH-1, then idle until requested.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_IDLE;
                end
                w_cnt_nxt = r_cnt + 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Word as it will look after this cycle's write: masked lanes from w_data.
    always_comb begin
        w_old = '0;
        if (w_waddr_ok) begin
            w_old = r_mem[bus.w_addr];
        end
        w_merged = w_old;
        for (int unsigned i = 0; i < NLANE; i++) begin
            if (bus.w_mask[i]) begin
                w_merged[i*LANE +: LANE] = bus.w_data[i*LANE +: LANE];
            end
        end
    end

    // Storage update: clear sweep has priority; writes are rejected while busy anyway.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_acc) begin
            r_mem[bus.w_addr] <= w_merged;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_raw;
        logic [WIDTH-1:0] r_buf;

        assign w_ra = bus.r_addr[p*AW +: AW];

        // Raw read word: zero when out of range, merged write word when bypassing.
        always_comb begin
            w_raw = '0;
            if ({1'b0, w_ra} < DEPTH_X) begin
                w_raw = r_mem[w_ra];
            end
            if (bus.wt_en && w_acc && (w_ra == bus.w_addr)) begin
                w_raw = w_merged;
            end
        end

        // Registered copy of the raw word, loaded every edge regardless of rd_buf.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_buf <= '0;
            end else begin
                r_buf <= w_raw;
            end
        end

        assign bus.r_data[p*WIDTH +: WIDTH] = bus.rd_buf[p] ? r_buf : w_raw;
    end
endmodule

// File: tb/tb_dffram_nr1w.sv
// Self-checking bench for dffram_nr1w against a word-array reference model.
module tb_dffram_nr1w;
    localparam int W  = 8;
    localparam int D  = 24;
    localparam int NR = 2;
    localparam int L  = 4;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dffram_nr1w_if #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .LANE(L)) bus ();

    dffram_nr1w #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .LANE(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word array, remaining clear edges, expected buffered words.
    logic [W-1:0] m [D];
    int           mclr;
    logic [W-1:0] exp_buf [NR];
    bit           buf_ok;

    function automatic logic [W-1:0] merge(logic [W-1:0] old, logic [W-1:0] d, logic [1:0] mk);
        logic [W-1:0] r;
        r = old;
        if (mk[0]) r[3:0] = d[3:0];
        if (mk[1]) r[7:4] = d[7:4];
        return r;
    endfunction

    function automatic bit accepted();
        return bus.w_en && (mclr == 0) && (int'(bus.w_addr) < D) && (bus.w_mask != 2'b00);
    endfunction

    function automatic bit exp_rej();
        return bus.w_en && ((mclr > 0) || (int'(bus.w_addr) >= D) || (bus.w_mask == 2'b00));
    endfunction

    function automatic logic [W-1:0] exp_raw(int p);
        int a;
        logic [W-1:0] v;
        a = int'(bus.r_addr[p*AW +: AW]);
        v = (a < D) ? m[a] : 8'h00;
        if (bus.wt_en && accepted() && a == int'(bus.w_addr))
            v = merge(v, bus.w_data, bus.w_mask);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_out(int p);
        return bus.rd_buf[p] ? exp_buf[p] : exp_raw(p);
    endfunction

    function automatic logic [W-1:0] port(int p);
        return bus.r_data[p*W +: W];
    endfunction

    task automatic quiet();
        bus.clear_req = 1'b0;
        bus.w_en      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.w_mask    = '0;
        bus.wt_en     = 1'b0;
        bus.rd_buf    = '0;
        bus.r_addr    = '0;
    endtask

    task automatic model_reset();
        for (int a = 0; a < D; a++) m[a] = '0;
        for (int p = 0; p < NR; p++) exp_buf[p] = '0;
        buf_ok = 1'b0;
        mclr   = D;
    endtask

    // One clock edge with the model advanced exactly as the rules say.
    task automatic step();
        bit acc;
        bit bok;
        logic [W-1:0] nb [NR];
        acc = accepted();
        bok = (mclr == 0);
        for (int p = 0; p < NR; p++) nb[p] = exp_raw(p);
        @(posedge clk);
        for (int p = 0; p < NR; p++) exp_buf[p] = nb[p];
        buf_ok = bok;
        if (mclr > 0) begin
            mclr--;
        end else begin
            if (acc) m[int'(bus.w_addr)] = merge(m[int'(bus.w_addr)], bus.w_data, bus.w_mask);
            if (bus.clear_req) begin
                mclr = D;
                for (int a = 0; a < D; a++) m[a] = '0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        bus.rd_buf = 2'b11;
        bus.w_en = 1'b1; bus.w_addr = 5'd3; bus.w_mask = 2'b11; bus.w_data = 8'h5A;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
        checks++; if (bus.w_rej !== 1'b1) begin errors++; $display("FAIL rst_wrej: got %b want 1", bus.w_rej); end
        checks++; if (bus.r_data !== 16'h0000) begin errors++; $display("FAIL rst_rbuf: got %h want 0000", bus.r_data); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 100) begin
            checks++; if (bus.w_rej !== 1'b1) begin errors++; $display("FAIL busy_wrej: got %b want 1 cyc %0d", bus.w_rej, n); end
            n++;
            step();
            @(negedge clk);
        end
        checks++; if (n != D) begin errors++; $display("FAIL rst_busy_len: got %0d want %0d", n, D); end
        bus.w_en = 1'b0;
        bus.rd_buf = 2'b10;
        for (int a = 0; a < D; a++) begin
            bus.r_addr = {5'(a), 5'(a)};
            @(negedge clk);
            checks++; if (port(0) !== 8'h00) begin errors++; $display("FAIL clr_word p0 a%0d: got %h want 00", a, port(0)); end
            if (buf_ok) begin
                checks++; if (port(1) !== exp_buf[1]) begin errors++; $display("FAIL clr_word p1 a%0d: got %h want %h", a, port(1), exp_buf[1]); end
            end
            step();
        end
    endtask

    task automatic test_masked_write();
        quiet();
        bus.r_addr = {5'd3, 5'd3};
        bus.w_en = 1'b1; bus.w_addr = 5'd3; bus.w_data = 8'hA5; bus.w_mask = 2'b11;
        @(negedge clk);
        checks++; if (bus.w_rej !== 1'b0) begin errors++; $display("FAIL mw_rej0: got %b want 0", bus.w_rej); end
        step();
        bus.w_data = 8'h3C; bus.w_mask = 2'b01;
        step();
        bus.w_en = 1'b0;
        @(negedge clk);
        checks++; if (port(1) !== 8'hAC) begin errors++; $display("FAIL mw_lane: got %h want ac", port(1)); end
        bus.w_en = 1'b1; bus.w_data = 8'hFF; bus.w_mask = 2'b00;
        @(negedge clk);
        checks++; if (bus.w_rej !== 1'b1) begin errors++; $display("FAIL mw_rej_mask0: got %b want 1", bus.w_rej); end
        step();
        bus.w_en = 1'b0;
        @(negedge clk);
        checks++; if (port(0) !== 8'hAC) begin errors++; $display("FAIL mw_keep: got %h want ac", port(0)); end
        step();
    endtask

    task automatic test_out_of_range();
        quiet();
        bus.w_en = 1'b1; bus.w_addr = 5'd24; bus.w_data = 8'hFF; bus.w_mask = 2'b11;
        @(negedge clk);
        checks++; if (bus.w_rej !== 1'b1) begin errors++; $display("FAIL oor_rej: got %b want 1", bus.w_rej); end
        step();
        bus.w_en = 1'b0;
        for (int a = 0; a < D; a++) begin
            bus.r_addr = {5'd31, 5'(a)};
            @(negedge clk);
            checks++; if (port(0) !== m[a]) begin errors++; $display("FAIL oor_scan a%0d: got %h want %h", a, port(0), m[a]); end
            checks++; if (port(1) !== 8'h00) begin errors++; $display("FAIL oor_read31: got %h want 00", port(1)); end
            step();
        end
    endtask

    task automatic test_bypass();
        quiet();
        bus.r_addr = {5'd0, 5'd5};
        bus.w_en = 1'b1; bus.w_addr = 5'd5; bus.w_data = 8'h11; bus.w_mask = 2'b11;
        step();
        bus.wt_en = 1'b1; bus.w_data = 8'hF0; bus.w_mask = 2'b10;
        @(negedge clk);
        checks++; if (port(0) !== 8'hF1) begin errors++; $display("FAIL bp_same_cyc: got %h want f1", port(0)); end
        step();
        bus.wt_en = 1'b0; bus.w_data = 8'h11; bus.w_mask = 2'b11;
        step();
        bus.w_data = 8'hF0; bus.w_mask = 2'b10;
        @(negedge clk);
        checks++; if (port(0) !== 8'h11) begin errors++; $display("FAIL nobp_old: got %h want 11", port(0)); end
        step();
        bus.w_en = 1'b0;
        @(negedge clk);
        checks++; if (port(0) !== 8'hF1) begin errors++; $display("FAIL nobp_next: got %h want f1", port(0)); end
        step();
    endtask

    task automatic test_buffered();
        quiet();
        bus.rd_buf = 2'b10;
        bus.r_addr = {5'd7, 5'd7};
        bus.w_en = 1'b1; bus.w_addr = 5'd7; bus.w_data = 8'h42; bus.w_mask = 2'b11;
        @(negedge clk);
        checks++; if (port(1) !== 8'h00) begin errors++; $display("FAIL buf_before: got %h want 00", port(1)); end
        step();
        bus.w_en = 1'b0;
        @(negedge clk);
        checks++; if (port(0) !== 8'h42) begin errors++; $display("FAIL buf_p0: got %h want 42", port(0)); end
        checks++; if (port(1) !== 8'h00) begin errors++; $display("FAIL buf_lag: got %h want 00", port(1)); end
        step();
        @(negedge clk);
        checks++; if (port(1) !== 8'h42) begin errors++; $display("FAIL buf_p1: got %h want 42", port(1)); end
        step();
    endtask

    task automatic test_random();
        quiet();
        for (int i = 0; i < 400; i++) begin
            bus.clear_req = ($urandom_range(0, 59) == 0);
            bus.w_en      = $urandom_range(0, 3) != 0;
            bus.w_addr    = 5'($urandom_range(0, 31));
            bus.w_data    = 8'($urandom);
            bus.w_mask    = 2'($urandom);
            bus.wt_en     = 1'($urandom);
            bus.rd_buf    = 2'($urandom);
            bus.r_addr    = {5'($urandom_range(0, 31)), ($urandom_range(0, 1) != 0) ? bus.w_addr : 5'($urandom_range(0, 31))};
            @(negedge clk);
            checks++; if (bus.busy !== (mclr > 0)) begin errors++; $display("FAIL rnd_busy i%0d: got %b want %b", i, bus.busy, mclr > 0); end
            checks++; if (bus.w_rej !== exp_rej()) begin errors++; $display("FAIL rnd_wrej i%0d: got %b want %b", i, bus.w_rej, exp_rej()); end
            for (int p = 0; p < NR; p++) begin
                if (bus.rd_buf[p] ? buf_ok : (mclr == 0)) begin
                    checks++;
                    if (port(p) !== exp_out(p)) begin
                        errors++; $display("FAIL rnd_rdata i%0d p%0d: got %h want %h", i, p, port(p), exp_out(p));
                    end
                end
            end
            step();
        end
        quiet();
        while (mclr > 0) step();
    endtask

    task automatic test_clear();
        int n;
        quiet();
        bus.w_en = 1'b1; bus.w_addr = 5'd9; bus.w_data = 8'h9C; bus.w_mask = 2'b11;
        step();
        bus.w_en = 1'b0;
        bus.clear_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_req_busy0: got %b want 0", bus.busy); end
        step();
        bus.clear_req = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 100) begin
            bus.clear_req = (n == 5);
            n++;
            step();
            @(negedge clk);
        end
        bus.clear_req = 1'b0;
        checks++; if (n != D) begin errors++; $display("FAIL clr_len: got %0d want %0d", n, D); end
        for (int a = 0; a < D; a++) begin
            bus.r_addr = {5'(a), 5'(a)};
            @(negedge clk);
            checks++; if (port(0) !== 8'h00) begin errors++; $display("FAIL clr_zero a%0d: got %h want 00", a, port(0)); end
            step();
        end
        bus.w_en = 1'b1; bus.w_addr = 5'd2; bus.w_data = 8'h77; bus.w_mask = 2'b11;
        step();
        bus.w_en = 1'b0;
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        bus.rd_buf = 2'b11;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", bus.busy); end
        checks++; if (bus.r_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_rbuf: got %h want 0000", bus.r_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            step();
            @(negedge clk);
        end
        checks++; if (n != D) begin errors++; $display("FAIL rst_mid_len: got %0d want %0d", n, D); end
        bus.rd_buf = 2'b00;
        bus.r_addr = {5'd9, 5'd2};
        @(negedge clk);
        checks++; if (port(0) !== 8'h00) begin errors++; $display("FAIL rst_mid_zero2: got %h want 00", port(0)); end
        checks++; if (port(1) !== 8'h00) begin errors++; $display("FAIL rst_mid_zero9: got %h want 00", port(1)); end
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        model_reset();
        test_reset();
        test_masked_write();
        test_out_of_range();
        test_bypass();
        test_buffered();
        test_random();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/dffram_nr1w.md
# dffram_nr1w

Parametrised flip-flop RAM with one masked write port and NREAD independent read ports; successor to the fixed 32x8 two-read-port tile. Width, depth (non-power-of-two allowed), read-port count and write-lane size are parameters. Per-port buffered/unbuffered read select, write-through bypass and a sequential clear engine are included; the clear engine zeroes storage, which has no reset. Sits between the tile's pin-mux logic and any future DFF-storage user (register files, scratchpads).

## Interface
- WIDTH, 8: word width in bits.
- DEPTH, 24: number of words; any value 2..256.
- NREAD, 2: number of read ports, 1..4.
- LANE, 4: write-mask granularity in bits; WIDTH % LANE == 0; NLANE = WIDTH/LANE.
- AW (derived): clog2(DEPTH).

- clk  in  1  the one clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- clear_req  in  1  request full-array zeroing; honoured only in IDLE.
- busy  out  1  high while reset asserted or clear engine running.
- w_en  in  1  write strobe.
- w_addr  in  AW  write address.
- w_data  in  WIDTH  write data.
- w_mask  in  NLANE  lane enables; lane i covers bits [i*LANE +: LANE].
- w_rej  out  1  combinational: w_en & (busy | w_addr >= DEPTH | w_mask == 0).
- wt_en  in  1  write-through bypass enable (quasi-static).
- rd_buf  in  NREAD  per-port: 1 = registered read, 0 = combinational read (quasi-static).
- r_addr  in  NREAD*AW  port p address at [p*AW +: AW].
- r_data  out  NREAD*WIDTH  port p data at [p*WIDTH +: WIDTH].

## Operation
- Storage: DEPTH x WIDTH plain DFFs, no reset. Only the clear engine and accepted writes modify it.
- Clear FSM, states IDLE and CLEAR; 
  - rst asserted: state=CLEAR, cnt=0, busy=1.
  - CLEAR: each clk edge writes zero to word cnt, cnt++; on the edge writing DEPTH-1, state -> IDLE.
  - IDLE: clear_req=1 on an edge -> CLEAR, cnt=0; busy rises the cycle after.
  - clear_req during CLEAR ignored (no restart); rst during CLEAR restarts from 0.
- Write accepted when w_en & !w_rej: lanes with w_mask[i]=1 take w_data, others retain.
- Rejected writes (busy, out-of-range, empty mask) change nothing; w_rej flags them the same cycle.
- Reads: address >= DEPTH returns all-zero data (no aliasing).
- Read word per port (raw): mem[r_addr_p], or zero if out of range.
- Bypass: if wt_en & write accepted this cycle & r_addr_p == w_addr, raw word is replaced by merged word (masked lanes from w_data, others from mem).
- rd_buf[p]=0: r_data_p = raw/bypassed word combinationally.
- rd_buf[p]=1: r_data_p = register loaded each edge with raw/bypassed word; register resets to 0.
- Reads during CLEAR return current (partially cleared) contents; no bypass since no write is accepted.

## Timing
- Reset values: busy=1, w_rej=w_en, buffered r_data=0, unbuffered r_data follows undefined storage (tests must not check before clear completes).
- After rst deasserts, busy stays 1 for exactly DEPTH edges; first edge clears word 0.
- Write latency: data visible on unbuffered read in the cycle after the accepting edge; on buffered read one cycle later, unless bypass.
- Bypass: unbuffered port sees new data same cycle as w_en; buffered port sees it after the accepting edge (same time as plain buffered read of stored value).
- Simultaneous accepted write and read of same address without wt_en: unbuffered returns old value that cycle; buffered register captures old value.
- All NREAD ports independent; any ports may share an address.

## Test plan
- Reset release, DEPTH=24: busy high 24 cycles then 0; all 24 words read 0 on every port; w_en during busy -> w_rej=1, mem unchanged.
- Write 0xA5 to addr 3 mask 2'b11, then mask 2'b01 with 0x3C -> addr 3 reads 0xAC; mask 0 -> w_rej=1, still 0xAC.
- Out of range: write addr 24 -> w_rej=1, no word changes; read addr 31 on port 1 -> 0x00.
- wt_en=1, rd_buf=0, port0 r_addr=5 holding 0x11, write 0xF0 mask 2'b10 -> port0 shows 0xF1 same cycle; wt_en=0 -> shows 0x11 that cycle, 0xF1 next.
- rd_buf=2'b10: port1 reading addr 7 (0x42) lags port0 by one cycle; after rst both buffered regs read 0.
- clear_req in IDLE -> busy next cycle for 24 cycles, all zero; clear_req mid-clear no extension; rst at cycle 10 of clear -> full 24-cycle clear restarts.
